// File: rtl/muldiv_sequencer.sv
// Iterative RV32M execute unit: shift-add multiplier and restoring divider that
// stalls the pipeline while busy and presents the result for exactly one cycle.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StartE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE
);

    // state   | meaning
    // IDLE    | waiting for an M op in E; captures operands on StartE & !FlushE
    // MUL     | one shift-add step per cycle on operand magnitudes
    // DIV     | one restoring step per cycle (shift, trial subtract, quotient bit)
    // SPECIAL | divide-by-zero / signed overflow, fixed result already held
    // DONE    | result valid for one cycle, StartE ignored
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_SPECIAL, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t                r_state;
    logic [2:0]            r_op;
    logic [CNT_W-1:0]      r_cnt;
    logic [XLEN-1:0]       r_b;
    logic [2*XLEN-1:0]     r_acc;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_done;
    logic [XLEN-1:0]       r_result;

    logic                  w_start;
    logic                  w_sa;
    logic                  w_sb;
    logic                  w_neg_a;
    logic                  w_neg_b;
    logic [XLEN-1:0]       w_mag_a;
    logic [XLEN-1:0]       w_mag_b;
    logic                  w_div_zero;
    logic                  w_overflow;
    logic [XLEN-1:0]       w_special;
    logic [XLEN:0]         w_mul_sum;
    logic [2*XLEN-1:0]     w_mul_next;
    logic [2*XLEN-1:0]     w_prod_fix;
    logic [XLEN:0]         w_rem_sh;
    logic [XLEN:0]         w_diff;
    logic                  w_ge;
    logic [2*XLEN-1:0]     w_div_next;
    logic [XLEN-1:0]       w_quot;
    logic [XLEN-1:0]       w_rem;
    logic [XLEN-1:0]       w_final;

    assign w_start    = StartE & ~FlushE;
    assign w_sa       = funct3E[2] ? ~funct3E[0] : (funct3E[1:0] != 2'b11);
    assign w_sb       = funct3E[2] ? ~funct3E[0] : ~funct3E[1];
    assign w_neg_a    = w_sa & SrcAE[XLEN-1];
    assign w_neg_b    = w_sb & SrcBE[XLEN-1];
    assign w_mag_a    = w_neg_a ? -SrcAE : SrcAE;
    assign w_mag_b    = w_neg_b ? -SrcBE : SrcBE;
    assign w_div_zero = funct3E[2] & (SrcBE == '0);
    assign w_overflow = funct3E[2] & ~funct3E[0] & (SrcAE == MIN_NEG) & (SrcBE == '1);
    // Overflow quotient equals the dividend (MIN_NEG); zero-divisor remainder is the dividend.
    assign w_special  = w_overflow ? (funct3E[1] ? '0 : SrcAE)
                                   : (funct3E[1] ? SrcAE : '1);

    // acc = {partial product, remaining multiplier bits}, shifted right each step
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_prod_fix = r_neg_q ? -w_mul_next : w_mul_next;

    // acc = {remainder, dividend bits shifting out / quotient bits shifting in}
    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_ge       = ~w_diff[XLEN];
    assign w_div_next = {(w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                         r_acc[XLEN-2:0], w_ge};
    assign w_quot     = w_div_next[XLEN-1:0];
    assign w_rem      = w_div_next[2*XLEN-1:XLEN];

    always_comb begin
        w_final = '0;
        case (r_op)
            3'b000:                 w_final = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = r_neg_q ? -w_quot : w_quot;
            default:                w_final = r_neg_r ? -w_rem : w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_cnt    <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start) begin
                        r_op    <= funct3E;
                        r_cnt   <= CNT_W'(XLEN-1);
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        if (w_div_zero || w_overflow) begin
                            r_acc   <= {{XLEN{1'b0}}, w_special};
                            r_state <= S_SPECIAL;
                        end else if (funct3E[2]) begin
                            r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                            r_b     <= w_mag_b;
                            r_state <= S_DIV;
                        end else begin
                            r_acc   <= {{XLEN{1'b0}}, w_mag_b};
                            r_b     <= w_mag_a;
                            r_state <= S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (FlushE) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= (r_state == S_MUL) ? w_mul_next : w_div_next;
                        if (r_cnt == '0) begin
                            r_result <= w_final;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_SPECIAL: begin
                    if (FlushE) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= r_acc[XLEN-1:0];
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Busy covers the capture cycle so F/D/E freeze before the first iteration.
    assign BusyE   = ((r_state == S_IDLE) & w_start) |
                     (r_state == S_MUL) | (r_state == S_DIV) | (r_state == S_SPECIAL);
    assign DoneE   = r_done;
    assign ResultE = r_result;

endmodule
